// File: rtl/branch_hazard_ctrl.sv
// Branch hazard controller for the ID stage of a 5-stage MIPS pipeline.
// Resolves beq/bne early: stalls IF/ID until the comparator operands are
// available, selects comparator forwarding, redirects the PC on taken
// branches and jumps, and keeps saturating performance counters.
//
// state | meaning
// ------+------------------------------------------------------------
// RUN   | normal flow; branches are evaluated and stalled or resolved
// STALL | forced load-use stall in progress; busy=1, ID held
module branch_hazard_ctrl #(
  parameter int          CNT_W  = 16,
  parameter logic [5:0]  OP_BEQ = 6'b000100,
  parameter logic [5:0]  OP_BNE = 6'b000101,
  parameter logic [5:0]  OP_J   = 6'b000010
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [5:0]       id_opcode,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             mem_regwrite,
  input  logic             mem_memread,
  input  logic [4:0]       mem_rd,
  input  logic             cmp_zero,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       pc_sel,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             busy,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  state_t     state, state_next;
  logic [1:0] stall_cnt, stall_cnt_next;
  logic       inc_br, inc_taken, inc_stall;
  logic       is_branch, is_jump;
  logic [1:0] need_rs, need_rt, need;
  logic       fwd_rs, fwd_rt;

  // Per-operand stall requirement: a load still in EX needs two cycles,
  // an ALU result in EX or a load in MEM needs one. $0 never hazards.
  function automatic logic [1:0] operand_need(
    input logic [4:0] r,
    input logic       exw, input logic exm, input logic [4:0] exd,
    input logic       mm,  input logic [4:0] md
  );
    logic [1:0] n;
    n = 2'd0;
    if (r != 5'd0) begin
      if (exm && exd == r)      n = 2'd2;
      else if (exw && exd == r) n = 2'd1;
      else if (mm && md == r)   n = 2'd1;
    end
    return n;
  endfunction

  // Hazard detection and forwarding match decode
  always_comb begin
    is_branch = id_valid && (id_opcode == OP_BEQ || id_opcode == OP_BNE);
    is_jump   = id_valid && (id_opcode == OP_J);
    need_rs   = operand_need(id_rs, ex_regwrite, ex_memread, ex_rd, mem_memread, mem_rd);
    need_rt   = operand_need(id_rt, ex_regwrite, ex_memread, ex_rd, mem_memread, mem_rd);
    need      = (need_rs > need_rt) ? need_rs : need_rt;
    fwd_rs    = mem_regwrite && !mem_memread && mem_rd != 5'd0 && mem_rd == id_rs;
    fwd_rt    = mem_regwrite && !mem_memread && mem_rd != 5'd0 && mem_rd == id_rt;
  end

  // Next-state and output decode; reset forces default outputs
  always_comb begin
    pc_write       = 1'b1;
    ifid_write     = 1'b1;
    ifid_flush     = 1'b0;
    idex_bubble    = 1'b0;
    pc_sel         = 2'b00;
    fwd_a          = 2'b00;
    fwd_b          = 2'b00;
    busy           = 1'b0;
    state_next     = state;
    stall_cnt_next = stall_cnt;
    inc_br         = 1'b0;
    inc_taken      = 1'b0;
    inc_stall      = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          if (is_branch) begin
            if (need != 2'd0) begin
              pc_write       = 1'b0;
              ifid_write     = 1'b0;
              idex_bubble    = 1'b1;
              inc_stall      = 1'b1;
              stall_cnt_next = need - 2'd1;
              state_next     = (need == 2'd2) ? STALL : RUN;
            end else begin
              fwd_a  = fwd_rs ? 2'b01 : 2'b00;
              fwd_b  = fwd_rt ? 2'b01 : 2'b00;
              inc_br = 1'b1;
              if (cmp_zero) begin
                pc_sel     = 2'b01;
                ifid_flush = 1'b1;
                inc_taken  = 1'b1;
              end
            end
          end else if (is_jump) begin
            pc_sel     = 2'b10;
            ifid_flush = 1'b1;
          end
        end
        STALL: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          busy        = 1'b1;
          inc_stall   = 1'b1;
          // The entering RUN cycle already counted as the first stall, so
          // the countdown terminates when the decremented value hits zero.
          if (stall_cnt <= 2'd1) begin
            stall_cnt_next = 2'd0;
            state_next     = RUN;
          end else begin
            stall_cnt_next = stall_cnt - 2'd1;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  // State, stall timer and saturating counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      stall_cnt   <= 2'd0;
      br_count    <= '0;
      taken_count <= '0;
      stall_count <= '0;
    end else begin
      state     <= state_next;
      stall_cnt <= stall_cnt_next;
      if (inc_br && br_count != '1)       br_count    <= br_count + 1'b1;
      if (inc_taken && taken_count != '1) taken_count <= taken_count + 1'b1;
      if (inc_stall && stall_count != '1) stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Scoreboard bench for branch_hazard_ctrl: directed scenarios followed by
// randomized traffic, compared against a cycle-level reference model.
module tb_branch_hazard_ctrl;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, JMP = 6'b000010, ADD = 6'b000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, id_valid, ex_regwrite, ex_memread, mem_regwrite, mem_memread, cmp_zero;
  logic [5:0] id_opcode;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, busy;
  logic [1:0] pc_sel, fwd_a, fwd_b;
  logic [CNT_W-1:0] br_count, taken_count, stall_count;

  branch_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_rd(mem_rd),
    .cmp_zero(cmp_zero), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .pc_sel(pc_sel),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .busy(busy), .br_count(br_count),
    .taken_count(taken_count), .stall_count(stall_count)
  );

  typedef struct packed {
    logic rst, valid; logic [5:0] op; logic [4:0] rs, rt;
    logic exw, exm; logic [4:0] exd; logic mw, mm; logic [4:0] md; logic cz;
  } stim_t;

  typedef struct {
    logic pcw, ifw, flush, bubble, busy; logic [1:0] pcs, fa, fb;
    int br, tk, st;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: remaining forced stall cycles plus counter values
  int m_forced = 0;
  int m_br = 0, m_tk = 0, m_st = 0;

  function automatic stim_t mk(logic r, logic v, logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                               logic exw, logic exm, logic [4:0] exd,
                               logic mw, logic mm, logic [4:0] md, logic cz);
    stim_t s;
    s = '{rst:r, valid:v, op:op, rs:rs, rt:rt, exw:exw, exm:exm, exd:exd,
          mw:mw, mm:mm, md:md, cz:cz};
    return s;
  endfunction

  function automatic int need_of(stim_t s, logic [4:0] r);
    if (r == 5'd0) return 0;
    if (s.exm && s.exd == r) return 2;
    if (s.exw && s.exd == r) return 1;
    if (s.mm && s.md == r) return 1;
    return 0;
  endfunction

  function automatic int sat_inc(int x);
    return (x >= CMAX) ? CMAX : x + 1;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    int need, nf;
    bit ib, it, is;
    @(negedge clk);
    rst = s.rst; id_valid = s.valid; id_opcode = s.op; id_rs = s.rs; id_rt = s.rt;
    ex_regwrite = s.exw; ex_memread = s.exm; ex_rd = s.exd;
    mem_regwrite = s.mw; mem_memread = s.mm; mem_rd = s.md; cmp_zero = s.cz;
    e = '{pcw:1, ifw:1, flush:0, bubble:0, busy:0, pcs:0, fa:0, fb:0,
          br:m_br, tk:m_tk, st:m_st};
    nf = m_forced; ib = 0; it = 0; is = 0;
    if (s.rst) begin
      nf = 0;
    end else if (m_forced > 0) begin
      e.pcw = 0; e.ifw = 0; e.bubble = 1; e.busy = 1; is = 1; nf = m_forced - 1;
    end else if (s.valid && (s.op == BEQ || s.op == BNE)) begin
      need = need_of(s, s.rs);
      if (need_of(s, s.rt) > need) need = need_of(s, s.rt);
      if (need > 0) begin
        e.pcw = 0; e.ifw = 0; e.bubble = 1; is = 1; nf = (need == 2) ? 1 : 0;
      end else begin
        if (s.mw && !s.mm && s.md != 0 && s.md == s.rs) e.fa = 2'b01;
        if (s.mw && !s.mm && s.md != 0 && s.md == s.rt) e.fb = 2'b01;
        ib = 1;
        if (s.cz) begin e.pcs = 2'b01; e.flush = 1; it = 1; end
      end
    end else if (s.valid && s.op == JMP) begin
      e.pcs = 2'b10; e.flush = 1;
    end
    q.push_back(e);
    @(posedge clk);
    m_forced = nf;
    if (s.rst) begin
      m_br = 0; m_tk = 0; m_st = 0;
    end else begin
      if (ib) m_br = sat_inc(m_br);
      if (it) m_tk = sat_inc(m_tk);
      if (is) m_st = sat_inc(m_st);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are present every cycle; compare settled values mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc_write",    {31'd0, pc_write},    {31'd0, e.pcw});
        chk("ifid_write",  {31'd0, ifid_write},  {31'd0, e.ifw});
        chk("ifid_flush",  {31'd0, ifid_flush},  {31'd0, e.flush});
        chk("idex_bubble", {31'd0, idex_bubble}, {31'd0, e.bubble});
        chk("busy",        {31'd0, busy},        {31'd0, e.busy});
        chk("pc_sel",      {30'd0, pc_sel},      {30'd0, e.pcs});
        chk("fwd_a",       {30'd0, fwd_a},       {30'd0, e.fa});
        chk("fwd_b",       {30'd0, fwd_b},       {30'd0, e.fb});
        chk("br_count",    32'(br_count),        32'(e.br));
        chk("taken_count", 32'(taken_count),     32'(e.tk));
        chk("stall_count", 32'(stall_count),     32'(e.st));
        if (!ifid_write && ifid_flush) chk("stall_and_flush", 32'd1, 32'd0);
      end
    end
  end

  stim_t idle;

  initial begin
    stim_t s;
    int budget;
    idle = mk(0, 0, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1; id_valid = 0; id_opcode = ADD; id_rs = 0; id_rt = 0;
    ex_regwrite = 0; ex_memread = 0; ex_rd = 0;
    mem_regwrite = 0; mem_memread = 0; mem_rd = 0; cmp_zero = 0;
    repeat (3) @(posedge clk);
    step(mk(1, 0, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(idle);

    // beq $1,$2 behind a load of $1: two stalls, then taken resolve
    step(mk(0, 1, BEQ, 1, 2, 1, 1, 1, 0, 0, 0, 0));
    step(mk(0, 1, BEQ, 1, 2, 0, 0, 0, 1, 1, 1, 0));
    step(mk(0, 1, BEQ, 1, 2, 0, 0, 0, 0, 0, 0, 1));
    step(idle);

    // bne $3,$4 behind ALU write of $4: one stall, then forward rt
    step(mk(0, 1, BNE, 3, 4, 1, 0, 4, 0, 0, 0, 0));
    step(mk(0, 1, BNE, 3, 4, 0, 0, 0, 1, 0, 4, 1));

    // beq $0,$5 with EX writing $0: no hazard, not taken
    step(mk(0, 1, BEQ, 0, 5, 1, 0, 0, 0, 0, 0, 0));

    // jump with a load hazard on its fields: never stalls
    step(mk(0, 1, JMP, 6, 7, 1, 1, 6, 0, 0, 0, 0));
    step(idle);

    // reset during the first stall cycle of a load-use branch
    step(mk(0, 1, BEQ, 9, 2, 1, 1, 9, 0, 0, 0, 0));
    step(mk(1, 1, BEQ, 9, 2, 0, 0, 0, 1, 1, 9, 0));
    step(mk(0, 0, ADD, 9, 2, 0, 0, 0, 0, 0, 0, 0));
    step(idle);

    // saturate taken/branch counters
    for (int i = 0; i < CMAX + 5; i++) step(mk(0, 1, BEQ, 1, 2, 0, 0, 0, 0, 0, 0, 1));
    step(idle);
    step(mk(1, 0, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // randomized traffic over a small register pool to provoke matches
    for (int i = 0; i < 4000; i++) begin
      logic [5:0] op;
      case ($urandom_range(0, 5))
        0, 1: op = BEQ;
        2, 3: op = BNE;
        4:    op = JMP;
        default: op = ADD;
      endcase
      s = mk(($urandom_range(0, 79) == 0), ($urandom_range(0, 9) != 0), op,
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom));
      step(s);
    end
    step(idle);

    budget = 20;
    while (q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    @(negedge clk);
    #3;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
